conv_encoder_sys: RTL and testbench

Rate-1/2 convolutional encoder, the transmit-side counterpart of decoder_sys.
- Takes a framed serial bit stream over a valid/ready handshake.
- Emits one 2-bit symbol per accepted bit.
- Appends K-1 zero tail bits per frame so the decoder's trellis terminates in state 0.
- Constraint length K is runtime-selectable (3-6) per frame with fixed best-known generator pairs; K=3 is the (7,5) octal code the decoder assumes.

---
 rtl/conv_code_pkg.sv | 36 +++
 rtl/conv_encoder_sys_if.sv | 25 ++
 rtl/conv_sym_gen.sv | 27 ++
 rtl/conv_encoder_sys.sv | 118 +++++++++++
 tb/tb_conv_encoder_sys.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_code_pkg.sv
// Shared definitions for the rate-1/2 convolutional encoder.
//   - state_e   : frame FSM states
//   - K_MIN/K_MAX : legal constraint-length range
//   - gen_pair  : {G0,G1} generator taps (6 bits each) for a given K
//   - parity    : XOR reduction
//   - sr_mask   : mask keeping only the K-1 live shift-register bits
package conv_code_pkg;

  typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

  localparam logic [2:0] K_MIN = 3'd3;
  localparam logic [2:0] K_MAX = 3'd6;

  // Taps are right-aligned: the MSB of a K-bit generator multiplies the newest input bit.
  function automatic logic [11:0] gen_pair(input logic [2:0] k);
    logic [11:0] g;
    unique case (k)
      3'd4:    g = {6'o17, 6'o15};
      3'd5:    g = {6'o23, 6'o35};
      3'd6:    g = {6'o53, 6'o75};
      default: g = {6'o07, 6'o05};
    endcase
    return g;
  endfunction

  function automatic logic parity(input logic [5:0] vec);
    return ^vec;
  endfunction

  function automatic logic [4:0] sr_mask(input logic [2:0] k);
    logic [5:0] m;
    m = (6'd1 << (k - 3'd1)) - 6'd1;
    return m[4:0];
  endfunction

endpackage

// File: rtl/conv_encoder_sys_if.sv
// Handshake bundle of the convolutional encoder.
//   Input side : choose_constraint_length, in_bit, in_last, in_valid -> in_ready
//   Output side: encoded_bits, sym_last, sym_valid -> sym_ready
// slave = encoder view, master = source/sink view.
interface conv_encoder_sys_if;
  logic [2:0] choose_constraint_length;
  logic       in_bit;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] encoded_bits;
  logic       sym_last;
  logic       sym_valid;
  logic       sym_ready;

  modport slave (
    input  choose_constraint_length, in_bit, in_last, in_valid, sym_ready,
    output in_ready, encoded_bits, sym_last, sym_valid
  );

  modport master (
    output choose_constraint_length, in_bit, in_last, in_valid, sym_ready,
    input  in_ready, encoded_bits, sym_last, sym_valid
  );
endinterface

// File: rtl/conv_sym_gen.sv
// Combinational symbol generator.
//   u   : current input bit
//   sr  : past bits, sr[0] most recent
//   k   : constraint length (3..6)
//   sym : {g0,g1}
module conv_sym_gen
  import conv_code_pkg::*;
(
  input  logic       u,
  input  logic [4:0] sr,
  input  logic [2:0] k,
  output logic [1:0] sym
);

  logic [5:0]  full;
  logic [5:0]  w;
  logic [11:0] gp;

  always_comb begin
    // Full 6-bit window, newest bit on top; shifting right leaves the K-bit window.
    full = {u, sr[0], sr[1], sr[2], sr[3], sr[4]};
    w    = full >> (3'd6 - k);
    gp   = gen_pair(k);
    sym  = {parity(gp[11:6] & w), parity(gp[5:0] & w)};
  end

endmodule

// File: rtl/conv_encoder_sys.sv
// Rate-1/2 convolutional encoder with per-frame K (3..6) and zero-tail termination.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : slave modport; bit stream in, 2-bit symbols out, valid/ready on both sides
module conv_encoder_sys
  import conv_code_pkg::*;
#(
  parameter bit          TAIL_ENABLE = 1'b1,
  parameter int unsigned DEFAULT_K   = 3
) (
  input  logic                clk,
  input  logic                rst,
  conv_encoder_sys_if.slave   bus
);

  state_e     state_q, state_d;
  logic [4:0] sr_q, sr_d;
  logic [2:0] k_q, k_d;
  logic [2:0] tail_cnt_q, tail_cnt_d;
  logic       sym_valid_q, sym_valid_d;
  logic [1:0] enc_q, enc_d;
  logic       last_q, last_d;

  logic       out_free;
  logic       accept;
  logic       launch;
  logic       u;
  logic [2:0] k_sel;
  logic [2:0] k_eff;
  logic [1:0] sym;

  assign out_free     = !sym_valid_q || bus.sym_ready;
  assign bus.in_ready = (state_q != StTail) && out_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign launch       = accept || ((state_q == StTail) && out_free);
  assign u            = accept ? bus.in_bit : 1'b0;

  assign k_sel = ((bus.choose_constraint_length < K_MIN) ||
                  (bus.choose_constraint_length > K_MAX)) ? 3'(DEFAULT_K)
                                                          : bus.choose_constraint_length;
  // K is only taken from the input on the first bit of a frame.
  assign k_eff = (state_q == StIdle) ? k_sel : k_q;

  conv_sym_gen u_sym_gen (
    .u   (u),
    .sr  (sr_q),
    .k   (k_eff),
    .sym (sym)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    k_d         = k_q;
    tail_cnt_d  = tail_cnt_q;
    sym_valid_d = sym_valid_q;
    enc_d       = enc_q;
    last_d      = last_q;

    if (out_free) sym_valid_d = 1'b0;

    if (launch) begin
      sym_valid_d = 1'b1;
      enc_d       = sym;
      last_d      = 1'b0;
      sr_d        = {sr_q[3:0], u} & sr_mask(k_eff);
    end

    if (accept) begin
      if (state_q == StIdle) begin
        k_d     = k_sel;
        state_d = StData;
      end
      if (bus.in_last) begin
        if (TAIL_ENABLE) begin
          state_d    = StTail;
          tail_cnt_d = k_eff - 3'd1;
        end else begin
          state_d = StIdle;
          sr_d    = '0;
          last_d  = 1'b1;
        end
      end
    end else if (launch) begin
      // Tail symbol with zero input.
      tail_cnt_d = tail_cnt_q - 3'd1;
      if (tail_cnt_q == 3'd1) begin
        last_d  = 1'b1;
        sr_d    = '0;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      k_q         <= 3'(DEFAULT_K);
      tail_cnt_q  <= '0;
      sym_valid_q <= 1'b0;
      enc_q       <= 2'b00;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      k_q         <= k_d;
      tail_cnt_q  <= tail_cnt_d;
      sym_valid_q <= sym_valid_d;
      enc_q       <= enc_d;
      last_q      <= last_d;
    end
  end

  assign bus.sym_valid    = sym_valid_q;
  assign bus.encoded_bits = enc_q;
  assign bus.sym_last     = last_q;

endmodule

// File: tb/tb_conv_encoder_sys.sv
// Directed self-checking bench for conv_encoder_sys. Symbols are collected as
// {sym_last, encoded_bits} on every output handshake and compared to hand-computed values.
module tb_conv_encoder_sys;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;

  logic [2:0] q[$];
  int         stamp[$];

  conv_encoder_sys_if bus ();

  conv_encoder_sys #(
    .TAIL_ENABLE (1'b1),
    .DEFAULT_K   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.sym_valid && bus.sym_ready) begin
      q.push_back({bus.sym_last, bus.encoded_bits});
      stamp.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_sym(input string tag, input int idx, input logic [2:0] exp);
    logic [7:0] obs;
    obs = (idx < q.size()) ? {5'b0, q[idx]} : 8'hff;
    chk($sformatf("%s[%0d]", tag, idx), obs, {5'b0, exp});
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic b, input logic l, input logic [2:0] k);
    bit ok;
    ok = 1'b0;
    bus.in_bit = b;
    bus.in_last = l;
    bus.choose_constraint_length = k;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("send_timeout", 8'd0, 8'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_syms(input string tag, input int n);
    for (int i = 0; i < 200; i++) begin
      if (q.size() >= n) break;
      @(negedge clk);
    end
    chk({tag, "_count"}, 8'(q.size()), 8'(n));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rst = 1'b1;
    bus.in_bit = 1'b0;
    bus.in_last = 1'b0;
    bus.in_valid = 1'b0;
    bus.choose_constraint_length = 3'd3;
    bus.sym_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_sym_valid", {7'b0, bus.sym_valid}, 8'd0);
    chk("rst_encoded", {6'b0, bus.encoded_bits}, 8'd0);
    chk("rst_sym_last", {7'b0, bus.sym_last}, 8'd0);
    chk("rst_k_reg", {5'b0, dut.k_q}, 8'd3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {7'b0, bus.in_ready}, 8'd1);
    @(negedge clk);

    // K=3 frame 1,0,1,1
    q.delete();
    send(1'b1, 1'b0, 3'd3);
    send(1'b0, 1'b0, 3'd3);
    send(1'b1, 1'b0, 3'd3);
    send(1'b1, 1'b1, 3'd3);
    wait_syms("k3", 6);
    chk_sym("k3", 0, 3'b0_11);
    chk_sym("k3", 1, 3'b0_10);
    chk_sym("k3", 2, 3'b0_00);
    chk_sym("k3", 3, 3'b0_01);
    chk_sym("k3", 4, 3'b0_01);
    chk_sym("k3", 5, 3'b1_11);
    chk("k3_sr_clear", {3'b0, dut.sr_q}, 8'd0);
    @(negedge clk);

    // K=4 impulse
    q.delete();
    send(1'b1, 1'b1, 3'd4);
    wait_syms("k4", 4);
    chk_sym("k4", 0, 3'b0_11);
    chk_sym("k4", 1, 3'b0_11);
    chk_sym("k4", 2, 3'b0_10);
    chk_sym("k4", 3, 3'b1_11);
    @(negedge clk);

    // Out-of-range K falls back to K=3
    q.delete();
    send(1'b1, 1'b1, 3'd7);
    wait_syms("k7", 3);
    chk_sym("k7", 0, 3'b0_11);
    chk_sym("k7", 1, 3'b0_10);
    chk_sym("k7", 2, 3'b1_11);
    @(negedge clk);

    // Mid-frame K change ignored
    q.delete();
    send(1'b1, 1'b0, 3'd3);
    send(1'b0, 1'b0, 3'd6);
    send(1'b1, 1'b0, 3'd5);
    send(1'b1, 1'b1, 3'd4);
    wait_syms("midk", 6);
    chk_sym("midk", 0, 3'b0_11);
    chk_sym("midk", 1, 3'b0_10);
    chk_sym("midk", 2, 3'b0_00);
    chk_sym("midk", 3, 3'b0_01);
    chk_sym("midk", 4, 3'b0_01);
    chk_sym("midk", 5, 3'b1_11);
    @(negedge clk);

    // Backpressure: 3 stalled cycles with next bit offered
    q.delete();
    bus.sym_ready = 1'b0;
    send(1'b1, 1'b0, 3'd3);
    bus.in_bit = 1'b0;
    bus.in_last = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", {7'b0, bus.sym_valid}, 8'd1);
      chk("bp_hold", {6'b0, bus.encoded_bits}, 8'b11);
      chk("bp_in_ready", {7'b0, bus.in_ready}, 8'd0);
      @(negedge clk);
    end
    bus.sym_ready = 1'b1;
    send(1'b0, 1'b0, 3'd3);
    send(1'b1, 1'b0, 3'd3);
    send(1'b1, 1'b1, 3'd3);
    wait_syms("bp", 6);
    chk_sym("bp", 0, 3'b0_11);
    chk_sym("bp", 1, 3'b0_10);
    chk_sym("bp", 2, 3'b0_00);
    chk_sym("bp", 3, 3'b0_01);
    chk_sym("bp", 4, 3'b0_01);
    chk_sym("bp", 5, 3'b1_11);
    @(negedge clk);

    // Reset while in tail
    q.delete();
    send(1'b1, 1'b1, 3'd3);
    chk("pre_rst_valid", {7'b0, bus.sym_valid}, 8'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {7'b0, bus.sym_valid}, 8'd0);
    chk("async_rst_last", {7'b0, bus.sym_last}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    send(1'b1, 1'b1, 3'd3);
    wait_syms("post_rst", 3);
    chk_sym("post_rst", 0, 3'b0_11);
    chk_sym("post_rst", 1, 3'b0_10);
    chk_sym("post_rst", 2, 3'b1_11);
    @(negedge clk);

    // Back-to-back frames, no idle gap
    q.delete();
    stamp.delete();
    send(1'b1, 1'b1, 3'd3);
    send(1'b0, 1'b1, 3'd3);
    wait_syms("b2b", 6);
    chk_sym("b2b", 0, 3'b0_11);
    chk_sym("b2b", 1, 3'b0_10);
    chk_sym("b2b", 2, 3'b1_11);
    chk_sym("b2b", 3, 3'b0_00);
    chk_sym("b2b", 4, 3'b0_00);
    chk_sym("b2b", 5, 3'b1_00);
    chk("b2b_span", 8'((stamp.size() >= 6) ? (stamp[5] - stamp[0]) : 255), 8'd5);
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
